// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and helpers for the data-RAM arbiter
// Contents: arbiter state encoding and the wait-counter width helper.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } dmem_arb_state_e;

  localparam int MAX_WAIT_DEFAULT = 16;
  localparam int WAIT_CW          = $clog2(MAX_WAIT_DEFAULT);

  // Width holding 0..max_wait-1; never narrower than one bit so MAX_WAIT=1 still elaborates.
  function automatic int wait_cw(input int max_wait);
    return (max_wait > 1) ? $clog2(max_wait) : 1;
  endfunction

endpackage

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - shares the data RAM between the MEM stage and the debug unit
// Ports:
//   clk, reset                              clock, synchronous active-high reset
//   pipe_req/we/addr/wdata, pipe_rdata      MEM stage access; rdata is ram_dout
//   pipe_stall                              freeze pipeline (only in the debug access cycle)
//   dbg_req/we/addr/wdata                   level request, sampled at accept
//   dbg_ack, dbg_rdata                      registered completion pulse and read data
//   stall_count                             saturating count of forced-stall cycles
//   ram_we/addr/din, ram_dout               single-port RAM, 1-cycle read latency
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W   = 13,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 16,
  parameter int STALL_CW = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pipe_req,
  input  logic                pipe_we,
  input  logic [ADDR_W-1:0]   pipe_addr,
  input  logic [DATA_W-1:0]   pipe_wdata,
  output logic [DATA_W-1:0]   pipe_rdata,
  output logic                pipe_stall,
  input  logic                dbg_req,
  input  logic                dbg_we,
  input  logic [ADDR_W-1:0]   dbg_addr,
  input  logic [DATA_W-1:0]   dbg_wdata,
  output logic                dbg_ack,
  output logic [DATA_W-1:0]   dbg_rdata,
  output logic [STALL_CW-1:0] stall_count,
  output logic                ram_we,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_din,
  input  logic [DATA_W-1:0]   ram_dout
);

  localparam int                 WCW       = wait_cw(MAX_WAIT);
  localparam logic [WCW-1:0]     WAIT_LAST = WCW'(MAX_WAIT - 1);

  dmem_arb_state_e state, state_next;

  logic [WCW-1:0]    wait_cnt;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;

  // The ack cycle masks dbg_req so a level still held from the finished request is not re-accepted.
  logic accept;
  logic wait_done;

  assign accept     = (state == ST_IDLE) && dbg_req && !dbg_ack;
  assign wait_done  = !pipe_req || (wait_cnt == WAIT_LAST);
  assign pipe_rdata = ram_dout;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    pipe_stall = 1'b0;
    ram_we     = pipe_req & pipe_we;
    ram_addr   = pipe_addr;
    ram_din    = pipe_wdata;
    case (state)
      ST_IDLE: begin
        if (accept) state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (wait_done) state_next = ST_ACCESS;
      end
      ST_ACCESS: begin
        // The stalled pipeline's write is dropped here; it repeats next cycle once unfrozen.
        ram_we     = lat_we;
        ram_addr   = lat_addr;
        ram_din    = lat_wdata;
        pipe_stall = pipe_req;
        state_next = ST_RESP;
      end
      ST_RESP: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt    <= '0;
      lat_we      <= 1'b0;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      dbg_ack     <= 1'b0;
      dbg_rdata   <= '0;
      stall_count <= '0;
    end else begin
      dbg_ack <= (state == ST_RESP);
      if (accept) begin
        lat_we    <= dbg_we;
        lat_addr  <= dbg_addr;
        lat_wdata <= dbg_wdata;
        wait_cnt  <= '0;
      end
      if ((state == ST_WAIT) && !wait_done) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if ((state == ST_ACCESS) && pipe_req && (stall_count != '1)) begin
        stall_count <= stall_count + 1'b1;
      end
      // ram_dout in the response cycle carries the read issued during the access cycle.
      if ((state == ST_RESP) && !lat_we) begin
        dbg_rdata <= ram_dout;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter
module tb_dmem_arbiter;

  localparam int ADDR_W   = 13;
  localparam int DATA_W   = 32;
  localparam int MAX_WAIT = 4;
  localparam int STALL_CW = 16;

  logic                clk = 1'b0;
  logic                reset;
  logic                pipe_req;
  logic                pipe_we;
  logic [ADDR_W-1:0]   pipe_addr;
  logic [DATA_W-1:0]   pipe_wdata;
  logic [DATA_W-1:0]   pipe_rdata;
  logic                pipe_stall;
  logic                dbg_req;
  logic                dbg_we;
  logic [ADDR_W-1:0]   dbg_addr;
  logic [DATA_W-1:0]   dbg_wdata;
  logic                dbg_ack;
  logic [DATA_W-1:0]   dbg_rdata;
  logic [STALL_CW-1:0] stall_count;
  logic                ram_we;
  logic [ADDR_W-1:0]   ram_addr;
  logic [DATA_W-1:0]   ram_din;
  logic [DATA_W-1:0]   ram_dout;

  dmem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT), .STALL_CW(STALL_CW)
  ) dut (
    .clk(clk), .reset(reset),
    .pipe_req(pipe_req), .pipe_we(pipe_we), .pipe_addr(pipe_addr),
    .pipe_wdata(pipe_wdata), .pipe_rdata(pipe_rdata), .pipe_stall(pipe_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata), .stall_count(stall_count),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // Single-port RAM, read-first, 1-cycle read latency.
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  int n_tests = 0;
  int n_fail  = 0;
  int n_acks  = 0;
  int n_stalls = 0;
  logic prev_stall = 1'b0;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] last_rd = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Each ack pops the expected dbg_rdata; writes expect the last read value to be held.
  task automatic push_rd(input logic [DATA_W-1:0] d);
    exp_q.push_back(d);
    last_rd = d;
  endtask

  task automatic push_wr();
    exp_q.push_back(last_rd);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (dbg_ack) begin
        n_acks++;
        if (exp_q.size() == 0) check("ack_unexpected", 1, 0);
        else check("dbg_rdata", dbg_rdata, exp_q.pop_front());
      end
      if (pipe_stall) begin
        n_stalls++;
        check("stall_consec", prev_stall, 0);
      end
      prev_stall = pipe_stall;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dbg_txn(input string tag, input logic we, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] wdata, input int hold,
                         output int lat, output int stall_idx);
    dbg_we = we; dbg_addr = addr; dbg_wdata = wdata; dbg_req = 1'b1;
    lat = 0; stall_idx = 0;
    while (!dbg_ack && lat < 40) begin
      tick();
      lat++;
      if (pipe_stall && stall_idx == 0) stall_idx = lat;
    end
    if (!dbg_ack) check({tag, "_timeout"}, 0, 1);
    repeat (hold) tick();
    dbg_req = 1'b0;
    tick();
  endtask

  task automatic wait_stall(input string tag);
    int n;
    n = 0;
    while (!pipe_stall && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_stall_seen"}, pipe_stall, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, sidx, s0, a0;
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
    mem[13'h010] = 32'hDEADBEEF;
    mem[13'h030] = 32'hCAFEF00D;
    mem[13'h040] = 32'h11112222;

    reset = 1'b1; pipe_req = 0; pipe_we = 0; pipe_addr = '0; pipe_wdata = '0;
    dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rst_ack", dbg_ack, 0);
    check("rst_rdata", dbg_rdata, 0);
    check("rst_stall_count", stall_count, 0);
    check("rst_pipe_stall", pipe_stall, 0);

    // 1: uncontended debug read
    s0 = n_stalls;
    push_rd(32'hDEADBEEF);
    dbg_txn("t1", 1'b0, 13'h010, '0, 0, lat, sidx);
    check("t1_latency", lat, 4);
    check("t1_no_stall", n_stalls - s0, 0);
    check("t1_stall_count", stall_count, 0);

    // 2: contended debug write, MAX_WAIT=4 forces one stall
    pipe_req = 1; pipe_we = 0; pipe_addr = 13'h100;
    s0 = n_stalls;
    push_wr();
    dbg_txn("t2", 1'b1, 13'h020, 32'h12345678, 0, lat, sidx);
    check("t2_latency", lat, MAX_WAIT + 3);
    check("t2_stall_pos", sidx, MAX_WAIT + 1);
    check("t2_stall_n", n_stalls - s0, 1);
    check("t2_stall_count", stall_count, 1);
    pipe_req = 0;
    tick();
    check("t2_ram", mem[13'h020], 32'h12345678);
    push_rd(32'h12345678);
    dbg_txn("t2r", 1'b0, 13'h020, '0, 0, lat, sidx);
    check("t2r_latency", lat, 4);

    // 3: pipeline read right after the debug access cycle
    push_rd(32'hDEADBEEF);
    dbg_we = 0; dbg_addr = 13'h010; dbg_req = 1;
    repeat (3) tick();
    check("t3_resp_no_ack", dbg_ack, 0);
    pipe_req = 1; pipe_we = 0; pipe_addr = 13'h030;
    tick();
    check("t3_pipe_rdata", pipe_rdata, 32'hCAFEF00D);
    check("t3_ack", dbg_ack, 1);
    check("t3_dbg_rdata", dbg_rdata, 32'hDEADBEEF);
    dbg_req = 0; pipe_req = 0;
    tick();

    // 4: held request gives one ack; re-raise after one low cycle is accepted at once
    a0 = n_acks;
    push_rd(32'hDEADBEEF);
    dbg_txn("t4a", 1'b0, 13'h010, '0, 1, lat, sidx);
    check("t4_ack_pulse", dbg_ack, 0);
    push_rd(32'h11112222);
    dbg_txn("t4b", 1'b0, 13'h040, '0, 0, lat, sidx);
    check("t4b_latency", lat, 4);
    repeat (6) tick();
    check("t4_ack_count", n_acks - a0, 2);

    // 5: reset in DBG_WAIT and in DBG_ACCESS
    a0 = n_acks; s0 = n_stalls;
    pipe_req = 1; pipe_we = 0; pipe_addr = 13'h100;
    dbg_we = 0; dbg_addr = 13'h010; dbg_req = 1;
    tick();
    reset = 1; dbg_req = 0;
    tick();
    reset = 0; last_rd = '0;
    check("t5w_ack", dbg_ack, 0);
    check("t5w_stall_count", stall_count, 0);
    check("t5w_pipe_stall", pipe_stall, 0);
    repeat (8) tick();
    check("t5w_no_ack", n_acks - a0, 0);
    check("t5w_no_stall", n_stalls - s0, 0);
    dbg_req = 1;
    wait_stall("t5a");
    reset = 1; dbg_req = 0;
    tick();
    reset = 0; last_rd = '0;
    check("t5a_ack", dbg_ack, 0);
    check("t5a_stall_count", stall_count, 0);
    check("t5a_pipe_stall", pipe_stall, 0);
    check("t5a_rdata", dbg_rdata, 0);
    repeat (8) tick();
    check("t5a_no_ack", n_acks - a0, 0);

    // 6: pipeline write is held off during the debug access cycle
    pipe_req = 1; pipe_we = 1; pipe_addr = 13'h050; pipe_wdata = 32'hAAAA5555;
    push_rd(32'h11112222);
    dbg_we = 0; dbg_addr = 13'h040; dbg_req = 1;
    wait_stall("t6");
    check("t6_acc_ram_we", ram_we, 0);
    check("t6_acc_ram_addr", ram_addr, 13'h040);
    tick();
    check("t6_resp_ram_we", ram_we, 1);
    check("t6_resp_ram_addr", ram_addr, 13'h050);
    check("t6_resp_stall", pipe_stall, 0);
    tick();
    check("t6_ack", dbg_ack, 1);
    dbg_req = 0; pipe_req = 0; pipe_we = 0;
    tick();
    push_rd(32'hAAAA5555);
    dbg_txn("t6r1", 1'b0, 13'h050, '0, 0, lat, sidx);
    push_rd(32'h11112222);
    dbg_txn("t6r2", 1'b0, 13'h040, '0, 0, lat, sidx);

    repeat (4) tick();
    check("sb_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
